// File: rtl/sub_32bit.sv
// sub_32bit: registered 32-bit subtractor with borrow-in and borrow-out.
//
// Computes {C_OUT, Z} = {1'b0, X} - {1'b0, Y} - C_IN through a 32-cell ripple
// chain of full-subtractor cells. The result is captured one clock after an
// in_valid strobe, and out_valid marks the cycle in which it is new.
//
// Optional feature: define SUB_32BIT_OVF_EN to add the registered signed
// overflow flag V.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   qualifies X, Y and C_IN
//   X          minuend
//   Y          subtrahend
//   C_IN       borrow-in (subtracts one extra)
//   Z          registered difference
//   C_OUT      registered unsigned borrow-out
//   out_valid  one-cycle pulse when Z/C_OUT (and V) hold a new result
//   V          registered signed overflow (SUB_32BIT_OVF_EN only)
module sub_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        C_IN,
  output logic [31:0] Z,
  output logic        C_OUT,
  output logic        out_valid
`ifdef SUB_32BIT_OVF_EN
  ,
  output logic        V
`endif
);

  logic [32:0] borrow;
  logic [31:0] diff;

  // Ripple chain: cell i takes x_i, y_i, b_i and yields d_i, b_{i+1}.
  always_comb begin
    borrow    = '0;
    diff      = '0;
    borrow[0] = C_IN;
    for (int i = 0; i < 32; i++) begin
      diff[i]     = X[i] ^ Y[i] ^ borrow[i];
      borrow[i+1] = (~X[i] & (Y[i] | borrow[i])) | (Y[i] & borrow[i]);
    end
  end

`ifdef SUB_32BIT_OVF_EN
  logic ovf;

  // Overflow only when operand signs differ and the result sign departs from X.
  always_comb begin
    ovf = (X[31] ^ Y[31]) & (diff[31] ^ X[31]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z         <= '0;
      C_OUT     <= 1'b0;
      out_valid <= 1'b0;
`ifdef SUB_32BIT_OVF_EN
      V         <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Z     <= diff;
        C_OUT <= borrow[32];
`ifdef SUB_32BIT_OVF_EN
        V     <= ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sub_32bit.sv
// Self-checking bench for sub_32bit: directed steps with a scoreboard queue of
// expected results, compared the cycle after each valid input.
module tb_sub_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] X;
  logic [31:0] Y;
  logic        C_IN;
  logic [31:0] Z;
  logic        C_OUT;
  logic        out_valid;
`ifdef SUB_32BIT_OVF_EN
  logic        V;
`endif

  sub_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .C_IN      (C_IN),
    .Z         (Z),
    .C_OUT     (C_OUT),
    .out_valid (out_valid)
`ifdef SUB_32BIT_OVF_EN
    ,
    .V         (V)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] z;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  // Reference: unsigned compare for borrow, wide signed arithmetic for overflow.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic cin);
    exp_t        e;
    longint      sx;
    longint      sy;
    longint      sd;
    logic [32:0] ysum;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    sd   = sx - sy - longint'(cin);
    ysum = {1'b0, y} + {32'b0, cin};
    e.z  = x - y - {31'b0, cin};
    e.c  = ({1'b0, x} < ysum);
    e.v  = (sd > MaxS) || (sd < MinS);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".Z"}, Z, e.z);
    chk({tag, ".C_OUT"}, {31'b0, C_OUT}, {31'b0, e.c});
`ifdef SUB_32BIT_OVF_EN
    chk({tag, ".V"}, {31'b0, V}, {31'b0, e.v});
`endif
  endtask

  // Drive one cycle of stimulus, then check the outputs just after the edge.
  task automatic step(input string tag, input logic vld, input logic [31:0] x,
                      input logic [31:0] y, input logic cin);
    exp_t e;
    @(negedge clk);
    in_valid = vld;
    X        = x;
    Y        = y;
    C_IN     = cin;
    if (vld) q.push_back(model(x, y, cin));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, vld});
    if (vld) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL %s.queue: observed empty expected entry", tag);
      end else begin
        e = q.pop_front();
        chk_out(tag, e);
        last = e;
      end
    end else begin
      chk_out({tag, ".hold"}, last);
    end
  endtask

  initial begin
    last     = '0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    X        = $urandom;
    Y        = $urandom;
    C_IN     = 1'b1;

    // Reset held with valid random traffic: outputs must stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      X    = $urandom;
      Y    = $urandom;
      C_IN = $urandom_range(0, 1);
      @(posedge clk);
      #1;
      chk("rst.Z", Z, 32'h0);
      chk("rst.C_OUT", {31'b0, C_OUT}, 32'h0);
      chk("rst.out_valid", {31'b0, out_valid}, 32'h0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst.Z", Z, 32'h0);
    chk("post_rst.C_OUT", {31'b0, C_OUT}, 32'h0);
    chk("post_rst.out_valid", {31'b0, out_valid}, 32'h0);

    // Borrow edge cases.
    step("b0_1_1", 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1);
    step("b1_1_1", 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1);
    step("b0_0_0", 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
    // Max values.
    step("max_x", 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    step("max_y", 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    // Signed overflow corner cases.
    step("ovf_a", 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
    step("ovf_b", 1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    step("ovf_c", 1'b1, 32'h7FFF_FFFE, 32'hFFFF_FFFE, 1'b1);
    step("ovf_d", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    // Idle cycle holds the last result.
    step("idle0", 1'b0, 32'h1234_5678, 32'h0000_0001, 1'b0);
    // Three back-to-back results, then a gap, then one more.
    step("pipe0", 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    step("pipe1", 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1);
    step("pipe2", 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
    step("idle1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step("pipe3", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    // A few random vectors.
    for (int i = 0; i < 8; i++) begin
      step("rand", 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-cycle discards the in-flight operation.
    step("pre_arst", 1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    X        = 32'h0000_0009;
    Y        = 32'h0000_0001;
    C_IN     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.Z", Z, 32'h0);
    chk("arst.out_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_edge.Z", Z, 32'h0);
    chk("arst_edge.out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    last     = '0;
    @(posedge clk);
    #1;
    chk("arst_rel.Z", Z, 32'h0);
    chk("arst_rel.out_valid", {31'b0, out_valid}, 32'h0);
    step("post_arst", 1'b1, 32'h0000_0010, 32'h0000_0001, 1'b1);

    chk("queue_empty", q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
